// File: rtl/exec_arbiter.sv
// Two-requester round-robin front end for a 2-cycle execute stage.
// One operation in flight: accept in IDLE, issue operands, capture result, hold response until taken.
module exec_arbiter #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iREQ0_VALID,
  input  logic [CW-1:0] iREQ0_CMD,
  input  logic [DW-1:0] iREQ0_SRC0,
  input  logic [DW-1:0] iREQ0_SRC1,
  output logic          oREQ0_READY,
  input  logic          iREQ1_VALID,
  input  logic [CW-1:0] iREQ1_CMD,
  input  logic [DW-1:0] iREQ1_SRC0,
  input  logic [DW-1:0] iREQ1_SRC1,
  output logic          oREQ1_READY,
  output logic [CW-1:0] oEXE_CMD,
  output logic [DW-1:0] oSOURCE0,
  output logic [DW-1:0] oSOURCE1,
  input  logic [DW-1:0] iRESULT,
  output logic          oRSP_VALID,
  output logic          oRSP_ID,
  output logic [DW-1:0] oRSP_DATA,
  input  logic          iRSP_READY,
  output logic          oBUSY,
  output logic [7:0]    oOP_COUNT
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t        r_state;
  logic          r_last;
  logic          r_id;
  logic [CW-1:0] r_cmd;
  logic [DW-1:0] r_src0;
  logic [DW-1:0] r_src1;
  logic          r_rsp_valid;
  logic          r_rsp_id;
  logic [DW-1:0] r_rsp_data;
  logic [7:0]    r_count;

  logic w_gnt0;
  logic w_gnt1;

  // r_last names the requester granted most recently; the other one wins a tie.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == IDLE) begin
      if (iREQ0_VALID && (!iREQ1_VALID || r_last))
        w_gnt0 = 1'b1;
      else if (iREQ1_VALID)
        w_gnt1 = 1'b1;
    end
  end

  // Reset parks the FSM in IDLE, so READY must also be masked by iRST itself.
  assign oREQ0_READY = w_gnt0 & ~iRST;
  assign oREQ1_READY = w_gnt1 & ~iRST;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_cmd       <= '0;
      r_src0      <= '0;
      r_src1      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0) begin
            r_cmd   <= iREQ0_CMD;
            r_src0  <= iREQ0_SRC0;
            r_src1  <= iREQ0_SRC1;
            r_id    <= 1'b0;
            r_last  <= 1'b0;
            r_state <= ISSUE;
          end else if (w_gnt1) begin
            r_cmd   <= iREQ1_CMD;
            r_src0  <= iREQ1_SRC0;
            r_src1  <= iREQ1_SRC1;
            r_id    <= 1'b1;
            r_last  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: r_state <= CAPT;
        CAPT: begin
          r_rsp_data  <= iRESULT;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (iRSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_count     <= r_count + 8'd1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oEXE_CMD   = r_cmd;
  assign oSOURCE0   = r_src0;
  assign oSOURCE1   = r_src1;
  assign oRSP_VALID = r_rsp_valid;
  assign oRSP_ID    = r_rsp_id;
  assign oRSP_DATA  = r_rsp_data;
  assign oBUSY      = (r_state != IDLE);
  assign oOP_COUNT  = r_count;

endmodule

// File: tb/tb_exec_arbiter.sv
// Directed bench for exec_arbiter with an execute model that registers src0+src1.
module tb_exec_arbiter;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b0;
  logic          iREQ0_VALID = 1'b0;
  logic [CW-1:0] iREQ0_CMD = '0;
  logic [DW-1:0] iREQ0_SRC0 = '0;
  logic [DW-1:0] iREQ0_SRC1 = '0;
  logic          oREQ0_READY;
  logic          iREQ1_VALID = 1'b0;
  logic [CW-1:0] iREQ1_CMD = '0;
  logic [DW-1:0] iREQ1_SRC0 = '0;
  logic [DW-1:0] iREQ1_SRC1 = '0;
  logic          oREQ1_READY;
  logic [CW-1:0] oEXE_CMD;
  logic [DW-1:0] oSOURCE0;
  logic [DW-1:0] oSOURCE1;
  logic [DW-1:0] iRESULT = '0;
  logic          oRSP_VALID;
  logic          oRSP_ID;
  logic [DW-1:0] oRSP_DATA;
  logic          iRSP_READY = 1'b0;
  logic          oBUSY;
  logic [7:0]    oOP_COUNT;

  int n_cmp = 0;
  int n_bad = 0;

  exec_arbiter #(.DW(DW), .CW(CW)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iREQ0_VALID(iREQ0_VALID), .iREQ0_CMD(iREQ0_CMD), .iREQ0_SRC0(iREQ0_SRC0),
    .iREQ0_SRC1(iREQ0_SRC1), .oREQ0_READY(oREQ0_READY),
    .iREQ1_VALID(iREQ1_VALID), .iREQ1_CMD(iREQ1_CMD), .iREQ1_SRC0(iREQ1_SRC0),
    .iREQ1_SRC1(iREQ1_SRC1), .oREQ1_READY(oREQ1_READY),
    .oEXE_CMD(oEXE_CMD), .oSOURCE0(oSOURCE0), .oSOURCE1(oSOURCE1),
    .iRESULT(iRESULT), .oRSP_VALID(oRSP_VALID), .oRSP_ID(oRSP_ID),
    .oRSP_DATA(oRSP_DATA), .iRSP_READY(iRSP_READY), .oBUSY(oBUSY),
    .oOP_COUNT(oOP_COUNT)
  );

  always #5 iCLK = ~iCLK;

  // Execute stage model: samples operands on the edge after issue.
  always @(posedge iCLK) iRESULT <= oSOURCE0 + oSOURCE1;

  always @(negedge iCLK) begin
    n_cmp++;
    if (oREQ0_READY && oREQ1_READY) begin
      n_bad++; $display("FAIL ready_exclusive: got both READY=1 want at most one");
    end
  end

  logic p_v, p_r, p_rst;
  always @(posedge iCLK) begin
    p_v = oRSP_VALID; p_r = iRSP_READY; p_rst = iRST;
    #1;
    if (p_v && !p_r && !p_rst && !iRST) begin
      n_cmp++;
      if (oRSP_VALID !== 1'b1) begin
        n_bad++; $display("FAIL rsp_valid_hold: got %b want 1", oRSP_VALID);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge iCLK); #2;
  endtask

  task automatic do_reset();
    iRST = 1'b1; iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0; iRSP_READY = 1'b0;
    tick(); tick();
    iRST = 1'b0; #1;
  endtask

  // Stimulus only: one REQ0 operation with iRSP_READY assumed high; flags a stall.
  task automatic run_op0(output int tmo);
    int b;
    tmo = 0;
    iREQ0_VALID = 1'b1; #1;
    b = 0;
    while (!oREQ0_READY && b < 8) begin tick(); b++; end
    if (!oREQ0_READY) tmo = 1;
    tick(); iREQ0_VALID = 1'b0;
    b = 0;
    while (!oRSP_VALID && b < 8) begin tick(); b++; end
    if (!oRSP_VALID) tmo = 1;
    tick();
  endtask

  task automatic test_reset();
    #1 iRST = 1'b1;
    iREQ0_VALID = 1'b1; iREQ1_VALID = 1'b1;
    #1;
    n_cmp++; if (oREQ0_READY !== 1'b0) begin n_bad++; $display("FAIL rst_ready0: got %b want 0", oREQ0_READY); end
    n_cmp++; if (oREQ1_READY !== 1'b0) begin n_bad++; $display("FAIL rst_ready1: got %b want 0", oREQ1_READY); end
    tick();
    n_cmp++; if (oBUSY !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", oBUSY); end
    n_cmp++; if (oRSP_VALID !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", oRSP_VALID); end
    n_cmp++; if (oRSP_ID !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_id: got %b want 0", oRSP_ID); end
    n_cmp++; if (oRSP_DATA !== 8'h00) begin n_bad++; $display("FAIL rst_rsp_data: got %h want 00", oRSP_DATA); end
    n_cmp++; if (oEXE_CMD !== 4'h0) begin n_bad++; $display("FAIL rst_cmd: got %h want 0", oEXE_CMD); end
    n_cmp++; if (oSOURCE0 !== 8'h00) begin n_bad++; $display("FAIL rst_src0: got %h want 00", oSOURCE0); end
    n_cmp++; if (oSOURCE1 !== 8'h00) begin n_bad++; $display("FAIL rst_src1: got %h want 00", oSOURCE1); end
    n_cmp++; if (oOP_COUNT !== 8'h00) begin n_bad++; $display("FAIL rst_count: got %h want 00", oOP_COUNT); end
    n_cmp++; if (oREQ0_READY !== 1'b0) begin n_bad++; $display("FAIL rst_ready0_hold: got %b want 0", oREQ0_READY); end
    iRST = 1'b0; #1;
    n_cmp++; if (oREQ0_READY !== 1'b1) begin n_bad++; $display("FAIL rst_first_grant0: got %b want 1", oREQ0_READY); end
    n_cmp++; if (oREQ1_READY !== 1'b0) begin n_bad++; $display("FAIL rst_first_grant1: got %b want 0", oREQ1_READY); end
    iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    iREQ0_CMD = 4'd1; iREQ0_SRC0 = 8'd5; iREQ0_SRC1 = 8'd3; iREQ0_VALID = 1'b1; #1;
    n_cmp++; if (oREQ0_READY !== 1'b1) begin n_bad++; $display("FAIL single_ready0: got %b want 1", oREQ0_READY); end
    n_cmp++; if (oREQ1_READY !== 1'b0) begin n_bad++; $display("FAIL single_ready1: got %b want 0", oREQ1_READY); end
    tick(); iREQ0_VALID = 1'b0; #1;
    n_cmp++; if (oREQ0_READY !== 1'b0) begin n_bad++; $display("FAIL single_ready_drop: got %b want 0", oREQ0_READY); end
    n_cmp++; if (oBUSY !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", oBUSY); end
    n_cmp++; if ({oEXE_CMD, oSOURCE0, oSOURCE1} !== {4'd1, 8'd5, 8'd3}) begin
      n_bad++; $display("FAIL single_issue: got %h/%h/%h want 1/05/03", oEXE_CMD, oSOURCE0, oSOURCE1); end
    tick();
    n_cmp++; if (oRSP_VALID !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b want 0", oRSP_VALID); end
    tick();
    n_cmp++; if (oRSP_VALID !== 1'b1) begin n_bad++; $display("FAIL single_latency: got %b want 1", oRSP_VALID); end
    n_cmp++; if (oRSP_ID !== 1'b0) begin n_bad++; $display("FAIL single_id: got %b want 0", oRSP_ID); end
    n_cmp++; if (oRSP_DATA !== 8'd8) begin n_bad++; $display("FAIL single_data: got %0d want 8", oRSP_DATA); end
    n_cmp++; if (oOP_COUNT !== 8'd0) begin n_bad++; $display("FAIL single_count_pre: got %0d want 0", oOP_COUNT); end
    iRSP_READY = 1'b1;
    tick(); iRSP_READY = 1'b0;
    n_cmp++; if (oRSP_VALID !== 1'b0) begin n_bad++; $display("FAIL single_valid_clr: got %b want 0", oRSP_VALID); end
    n_cmp++; if (oOP_COUNT !== 8'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", oOP_COUNT); end
    n_cmp++; if (oBUSY !== 1'b0) begin n_bad++; $display("FAIL single_idle: got %b want 0", oBUSY); end
    n_cmp++; if (oRSP_DATA !== 8'd8) begin n_bad++; $display("FAIL single_data_hold: got %0d want 8", oRSP_DATA); end
    n_cmp++; if (oSOURCE0 !== 8'd5) begin n_bad++; $display("FAIL single_src_hold: got %0d want 5", oSOURCE0); end
  endtask

  task automatic test_contention();
    do_reset();
    iREQ0_CMD = 4'd2; iREQ0_SRC0 = 8'd10; iREQ0_SRC1 = 8'd20; iREQ0_VALID = 1'b1;
    iREQ1_CMD = 4'd3; iREQ1_SRC0 = 8'd7;  iREQ1_SRC1 = 8'd100; iREQ1_VALID = 1'b1;
    #1;
    n_cmp++; if ({oREQ0_READY, oREQ1_READY} !== 2'b10) begin n_bad++; $display("FAIL cont_grant_a: got %b want 10", {oREQ0_READY, oREQ1_READY}); end
    tick();
    iREQ0_CMD = 4'd4; iREQ0_SRC0 = 8'd1; iREQ0_SRC1 = 8'd2; #1;
    n_cmp++; if ({oREQ0_READY, oREQ1_READY} !== 2'b00) begin n_bad++; $display("FAIL cont_busy_ready: got %b want 00", {oREQ0_READY, oREQ1_READY}); end
    n_cmp++; if (oEXE_CMD !== 4'd2) begin n_bad++; $display("FAIL cont_cmd_a: got %0d want 2", oEXE_CMD); end
    tick(); tick();
    n_cmp++; if ({oRSP_VALID, oRSP_ID, oRSP_DATA} !== {1'b1, 1'b0, 8'd30}) begin
      n_bad++; $display("FAIL cont_rsp_a: got %b/%b/%0d want 1/0/30", oRSP_VALID, oRSP_ID, oRSP_DATA); end
    iRSP_READY = 1'b1; tick(); iRSP_READY = 1'b0; #1;
    n_cmp++; if ({oREQ0_READY, oREQ1_READY} !== 2'b01) begin n_bad++; $display("FAIL cont_grant_b: got %b want 01", {oREQ0_READY, oREQ1_READY}); end
    tick();
    iREQ1_CMD = 4'd5; iREQ1_SRC0 = 8'd50; iREQ1_SRC1 = 8'd60;
    n_cmp++; if ({oEXE_CMD, oSOURCE0, oSOURCE1} !== {4'd3, 8'd7, 8'd100}) begin
      n_bad++; $display("FAIL cont_issue_b: got %h/%h/%h want 3/07/64", oEXE_CMD, oSOURCE0, oSOURCE1); end
    tick(); tick();
    n_cmp++; if ({oRSP_VALID, oRSP_ID, oRSP_DATA} !== {1'b1, 1'b1, 8'd107}) begin
      n_bad++; $display("FAIL cont_rsp_b: got %b/%b/%0d want 1/1/107", oRSP_VALID, oRSP_ID, oRSP_DATA); end
    iRSP_READY = 1'b1; tick(); iRSP_READY = 1'b0; #1;
    n_cmp++; if ({oREQ0_READY, oREQ1_READY} !== 2'b10) begin n_bad++; $display("FAIL cont_grant_c: got %b want 10", {oREQ0_READY, oREQ1_READY}); end
    tick();
    n_cmp++; if (oEXE_CMD !== 4'd4) begin n_bad++; $display("FAIL cont_cmd_c: got %0d want 4", oEXE_CMD); end
    tick(); tick();
    n_cmp++; if ({oRSP_VALID, oRSP_ID, oRSP_DATA} !== {1'b1, 1'b0, 8'd3}) begin
      n_bad++; $display("FAIL cont_rsp_c: got %b/%b/%0d want 1/0/3", oRSP_VALID, oRSP_ID, oRSP_DATA); end
    iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0;
    iRSP_READY = 1'b1; tick(); iRSP_READY = 1'b0;
    n_cmp++; if (oOP_COUNT !== 8'd3) begin n_bad++; $display("FAIL cont_count: got %0d want 3", oOP_COUNT); end
  endtask

  task automatic test_backpressure();
    do_reset();
    iREQ1_CMD = 4'd6; iREQ1_SRC0 = 8'h40; iREQ1_SRC1 = 8'h11; iREQ1_VALID = 1'b1; #1;
    n_cmp++; if ({oREQ0_READY, oREQ1_READY} !== 2'b01) begin n_bad++; $display("FAIL bp_grant: got %b want 01", {oREQ0_READY, oREQ1_READY}); end
    tick(); iREQ1_VALID = 1'b0;
    tick(); tick();
    iREQ0_CMD = 4'd1; iREQ0_SRC0 = 8'd1; iREQ0_SRC1 = 8'd1; iREQ0_VALID = 1'b1;
    iREQ1_VALID = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({oRSP_VALID, oRSP_ID, oRSP_DATA} !== {1'b1, 1'b1, 8'h51}) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got %b/%b/%h want 1/1/51", i, oRSP_VALID, oRSP_ID, oRSP_DATA); end
      n_cmp++; if ({oREQ0_READY, oREQ1_READY} !== 2'b00) begin
        n_bad++; $display("FAIL bp_ready[%0d]: got %b want 00", i, {oREQ0_READY, oREQ1_READY}); end
      n_cmp++; if (oOP_COUNT !== 8'd0) begin n_bad++; $display("FAIL bp_count[%0d]: got %0d want 0", i, oOP_COUNT); end
      tick();
    end
    iRSP_READY = 1'b1; tick();
    iRSP_READY = 1'b0; iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0; #1;
    n_cmp++; if (oRSP_VALID !== 1'b0) begin n_bad++; $display("FAIL bp_valid_clr: got %b want 0", oRSP_VALID); end
    n_cmp++; if (oOP_COUNT !== 8'd1) begin n_bad++; $display("FAIL bp_count_once: got %0d want 1", oOP_COUNT); end
    n_cmp++; if (oRSP_DATA !== 8'h51) begin n_bad++; $display("FAIL bp_data_hold: got %h want 51", oRSP_DATA); end
  endtask

  task automatic test_overflow();
    int to;
    int tmo_total;
    do_reset();
    iRSP_READY = 1'b1;
    iREQ0_CMD = 4'd9; iREQ0_SRC0 = 8'd9; iREQ0_SRC1 = 8'd250; iREQ0_VALID = 1'b1; #1;
    tick(); iREQ0_VALID = 1'b0;
    tick(); tick();
    n_cmp++; if ({oRSP_VALID, oRSP_DATA} !== {1'b1, 8'd3}) begin
      n_bad++; $display("FAIL ovf_data: got %b/%0d want 1/3", oRSP_VALID, oRSP_DATA); end
    tick();
    n_cmp++; if (oOP_COUNT !== 8'd1) begin n_bad++; $display("FAIL ovf_count1: got %0d want 1", oOP_COUNT); end
    tmo_total = 0;
    for (int k = 0; k < 254; k++) begin run_op0(to); tmo_total += to; end
    n_cmp++; if (oOP_COUNT !== 8'd255) begin n_bad++; $display("FAIL ovf_count255: got %0d want 255", oOP_COUNT); end
    run_op0(to); tmo_total += to;
    n_cmp++; if (oOP_COUNT !== 8'd0) begin n_bad++; $display("FAIL ovf_wrap: got %0d want 0", oOP_COUNT); end
    n_cmp++; if (tmo_total !== 0) begin n_bad++; $display("FAIL ovf_stall: got %0d stalls want 0", tmo_total); end
    iRSP_READY = 1'b0;
  endtask

  task automatic test_async_reset();
    int to;
    do_reset();
    iRSP_READY = 1'b1;
    iREQ0_CMD = 4'd7; iREQ0_SRC0 = 8'd4; iREQ0_SRC1 = 8'd4;
    run_op0(to);
    n_cmp++; if ({to[0], oOP_COUNT} !== {1'b0, 8'd1}) begin n_bad++; $display("FAIL ar_pre_count: got %0d/%0d want 0/1", to, oOP_COUNT); end
    iRSP_READY = 1'b0;
    iREQ0_VALID = 1'b1; #1;
    tick(); iREQ0_VALID = 1'b0;
    tick();
    n_cmp++; if ({oBUSY, oEXE_CMD} !== {1'b1, 4'd7}) begin n_bad++; $display("FAIL ar_in_capt: got %b/%0d want 1/7", oBUSY, oEXE_CMD); end
    #3 iRST = 1'b1;
    #1;
    n_cmp++; if ({oEXE_CMD, oSOURCE0, oSOURCE1} !== '0) begin
      n_bad++; $display("FAIL ar_operands: got %h/%h/%h want 0/00/00", oEXE_CMD, oSOURCE0, oSOURCE1); end
    n_cmp++; if ({oBUSY, oRSP_VALID, oOP_COUNT, oRSP_DATA} !== '0) begin
      n_bad++; $display("FAIL ar_state: got %b/%b/%0d/%0d want 0/0/0/0", oBUSY, oRSP_VALID, oOP_COUNT, oRSP_DATA); end
    #2 iRST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if ({oRSP_VALID, oBUSY} !== 2'b00) begin
        n_bad++; $display("FAIL ar_no_rsp[%0d]: got %b/%b want 0/0", i, oRSP_VALID, oBUSY); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_overflow();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exec_arbiter.md
EXEC_ARBITER -- requirements
Module: exec_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- DW, 8, data width of sources and result.
- CW, 4, execute command width.
REQ-002 Ports SHALL be, one per line:
- iCLK  input  1  single clock; all state updates on posedge.
- iRST  input  1  reset, asynchronous, active-high.
- iREQ0_VALID  input  1  requester 0 has an operation pending.
- iREQ0_CMD  input  CW  requester 0 execute command.
- iREQ0_SRC0 / iREQ0_SRC1  input  DW  requester 0 operands.
- oREQ0_READY  output  1  requester 0 operation accepted this cycle.
- iREQ1_VALID, iREQ1_CMD, iREQ1_SRC0, iREQ1_SRC1, oREQ1_READY: same as requester 0.
- oEXE_CMD  output  CW  command to execute stage.
- oSOURCE0 / oSOURCE1  output  DW  operands to execute stage.
- iRESULT  input  DW  registered result from execute stage.
- oRSP_VALID  output  1  response available.
- oRSP_ID  output  1  requester that owns the response.
- oRSP_DATA  output  DW  result returned to the requester.
- iRSP_READY  input  1  response consumer accepts.
- oBUSY  output  1  state is not IDLE.
- oOP_COUNT  output  8  completed-operation count.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, CAPT, RESP; all transitions on posedge iCLK.
REQ-004 Grant SHALL be computed combinationally in IDLE only: one valid requester is granted; with both valid, the requester not granted last is granted (round-robin).
REQ-005 oREQn_READY SHALL be 1 only when state==IDLE and requester n is granted; both READYs SHALL never be 1 in the same cycle.
REQ-006 A handshake (VALID & READY) at edge E0 SHALL register CMD/SRC0/SRC1 into oEXE_CMD/oSOURCE0/oSOURCE1, record the granted ID, update the last-grant pointer, and move to ISSUE.
REQ-007 ISSUE -> CAPT SHALL occur unconditionally at E1; at E1 the execute stage samples the operands.
REQ-008 CAPT -> RESP SHALL occur unconditionally at E2, registering iRESULT into oRSP_DATA, asserting oRSP_VALID and driving oRSP_ID with the recorded ID.
REQ-009 Latency SHALL be exactly 2 cycles from the accept edge to oRSP_VALID=1.
REQ-010 In RESP, oRSP_VALID, oRSP_ID and oRSP_DATA SHALL hold stable until iRSP_READY=1 at an edge.
REQ-011 At that edge the state SHALL return to IDLE, oRSP_VALID SHALL clear, and oOP_COUNT SHALL increment.
REQ-012 No new request SHALL be accepted before the state is IDLE again; minimum issue interval is 4 cycles.
REQ-013 oEXE_CMD/oSOURCE0/oSOURCE1 SHALL hold their last issued values outside ISSUE.
REQ-014 oRSP_DATA SHALL hold its last value after the response handshake.
REQ-015 oOP_COUNT SHALL wrap 255 -> 0 without a flag.
REQ-016 oBUSY SHALL equal (state != IDLE).
REQ-017 Requester VALID or operands changing while not accepted SHALL not affect the block; requesters hold them until READY.
REQ-018 A requester deasserting VALID before grant SHALL simply lose arbitration; no state is retained for it.

Reset
REQ-019 iRST=1 SHALL immediately, independent of iCLK, force:
- state IDLE; oRSP_VALID=0; oRSP_ID=0; oRSP_DATA=0.
- oEXE_CMD=0; oSOURCE0=0; oSOURCE1=0; oOP_COUNT=0.
- last-grant pointer=1, so requester 0 wins the first contention.
REQ-020 Reset mid-operation (ISSUE/CAPT/RESP) SHALL discard the in-flight operation; no response is produced for it after release.
REQ-021 While iRST=1, both oREQn_READY SHALL be 0.

Verification
Bench uses an execute model that registers src0+src1 on posedge.
REQ-022 Single request: REQ0 cmd=1, 5+3 -> READY0 one cycle; oRSP_VALID after 2 cycles; ID=0, DATA=8; oOP_COUNT 0->1 on handshake.
REQ-023 Contention: both valid from reset -> REQ0 granted first; after its response REQ1 granted; third contention grants REQ0 again.
REQ-024 Backpressure: iRSP_READY=0 for 5 cycles in RESP -> VALID/ID/DATA stable, no READY to either requester, count unchanged; then accepted once.
REQ-025 Overflow: 9+250 -> DATA=3 (mod 256); 256 completed ops -> oOP_COUNT returns to 0.
REQ-026 Async reset asserted mid-cycle in CAPT -> outputs zero before next edge; after release no oRSP_VALID for the aborted op.
REQ-027 Assertion throughout: READY0 & READY1 never both 1; oRSP_VALID never drops without iRSP_READY or reset.
